// File: rtl/param_alu_datapath.sv
// Parametrised register-file / ALU datapath behind a valid/ready request port.
// Each request walks IDLE -> EXEC -> WB; operands are captured at accept, the
// result and flags are written at WB together with a one-cycle Rsp_Valid.
// Optional feature macro: PARAM_ALU_DATAPATH_MUL_EN turns opcode F from NOP
// into an iterative shift-add multiply (WIDTH cycles in StMul).
module param_alu_datapath #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREG  = 8,
  parameter int unsigned RAW   = $clog2(NREG)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Req_Valid,
  output logic             Req_Ready,
  input  logic [3:0]       Req_Op,
  input  logic [RAW-1:0]   Req_Dst,
  input  logic [RAW-1:0]   Req_SrcA,
  input  logic [RAW-1:0]   Req_SrcB,
  input  logic [WIDTH-1:0] Req_Imm,
  input  logic             Req_WF,
  output logic             Rsp_Valid,
  output logic [WIDTH-1:0] Rsp_Data,
  output logic [3:0]       FlagsOut,
  input  logic [RAW-1:0]   Dbg_Sel,
  output logic [WIDTH-1:0] Dbg_Data
);

  localparam logic [3:0] OpMov = 4'h0, OpLdi = 4'h1, OpAdd = 4'h2, OpAdc = 4'h3;
  localparam logic [3:0] OpSub = 4'h4, OpAnd = 4'h5, OpOr  = 4'h6, OpXor = 4'h7;
  localparam logic [3:0] OpNot = 4'h8, OpLsl = 4'h9, OpLsr = 4'hA, OpAsr = 4'hB;
  localparam logic [3:0] OpCsl = 4'hC, OpCsr = 4'hD, OpCmp = 4'hE, OpMulNop = 4'hF;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StWb
`ifdef PARAM_ALU_DATAPATH_MUL_EN
    , StMul
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [RAW-1:0]   dst_q, dst_d;
  logic             wf_q, wf_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       nflags_q, nflags_d;
  logic [WIDTH-1:0] rf_q [NREG];
  logic [WIDTH-1:0] rf_d [NREG];
  logic [3:0]       flags_q, flags_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_o;
  logic [WIDTH:0]   add_ext, sub_ext;
  logic             is_nop;

`ifdef PARAM_ALU_DATAPATH_MUL_EN
  localparam int unsigned CntW = $clog2(WIDTH);
  logic [2*WIDTH-1:0] mul_q, mul_d, mul_next;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]     mul_sum;

  // One shift-add step: conditionally add A into the high half, then shift right.
  assign mul_sum  = {1'b0, mul_q[2*WIDTH-1:WIDTH]} + (mul_q[0] ? {1'b0, a_q} : '0);
  assign mul_next = {mul_sum, mul_q[WIDTH-1:1]};
  assign is_nop   = 1'b0;
`else
  assign is_nop   = (op_q == OpMulNop);
`endif

  assign Req_Ready = (state_q == StIdle);
  assign Rsp_Valid = rsp_valid_q;
  assign Rsp_Data  = rsp_data_q;
  assign FlagsOut  = flags_q;
  assign Dbg_Data  = rf_q[Dbg_Sel];

  // ALU on the latched operands; flags cannot change while an op is in flight,
  // so flags_q[2] is still the carry as it stood at accept.
  always_comb begin
    alu_res = '0;
    alu_c   = flags_q[2];
    alu_o   = flags_q[0];
    add_ext = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, flags_q[2] & (op_q == OpAdc)};
    sub_ext = {1'b0, a_q} - {1'b0, b_q};
    case (op_q)
      OpMov: alu_res = a_q;
      OpLdi: alu_res = imm_q;
      OpAdd, OpAdc: begin
        alu_res = add_ext[WIDTH-1:0];
        alu_c   = add_ext[WIDTH];
        alu_o   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_ext[WIDTH-1] != a_q[WIDTH-1]);
      end
      OpSub, OpCmp: begin
        alu_res = sub_ext[WIDTH-1:0];
        alu_c   = ~sub_ext[WIDTH];
        alu_o   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_ext[WIDTH-1] != a_q[WIDTH-1]);
      end
      OpAnd: alu_res = a_q & b_q;
      OpOr:  alu_res = a_q | b_q;
      OpXor: alu_res = a_q ^ b_q;
      OpNot: alu_res = ~a_q;
      OpLsl: begin alu_res = {a_q[WIDTH-2:0], 1'b0};         alu_c = a_q[WIDTH-1]; end
      OpLsr: begin alu_res = {1'b0, a_q[WIDTH-1:1]};         alu_c = a_q[0];       end
      OpAsr: begin alu_res = {a_q[WIDTH-1], a_q[WIDTH-1:1]}; alu_c = a_q[0];       end
      OpCsl: begin alu_res = {a_q[WIDTH-2:0], flags_q[2]};   alu_c = a_q[WIDTH-1]; end
      OpCsr: begin alu_res = {flags_q[2], a_q[WIDTH-1:1]};   alu_c = a_q[0];       end
      default: alu_res = '0;
    endcase
  end

  // Sequencer: accept, execute (or multiply), write back and respond.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    dst_d       = dst_q;
    wf_d        = wf_q;
    imm_d       = imm_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    nflags_d    = nflags_q;
    rf_d        = rf_q;
    flags_d     = flags_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
`ifdef PARAM_ALU_DATAPATH_MUL_EN
    mul_d       = mul_q;
    cnt_d       = cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (Req_Valid) begin
          op_d    = Req_Op;
          dst_d   = Req_Dst;
          wf_d    = Req_WF;
          imm_d   = Req_Imm;
          a_d     = rf_q[Req_SrcA];
          b_d     = rf_q[Req_SrcB];
          state_d = StExec;
        end
      end
      StExec: begin
        res_d    = alu_res;
        nflags_d = {alu_res == '0, alu_c, alu_res[WIDTH-1], alu_o};
        state_d  = StWb;
`ifdef PARAM_ALU_DATAPATH_MUL_EN
        if (op_q == OpMulNop) begin
          mul_d   = {{WIDTH{1'b0}}, b_q};
          cnt_d   = '0;
          state_d = StMul;
        end
`endif
      end
`ifdef PARAM_ALU_DATAPATH_MUL_EN
      StMul: begin
        mul_d = mul_next;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          res_d    = mul_next[WIDTH-1:0];
          nflags_d = {mul_next[WIDTH-1:0] == '0, |mul_next[2*WIDTH-1:WIDTH],
                      mul_next[WIDTH-1], flags_q[0]};
          state_d  = StWb;
        end
      end
`endif
      StWb: begin
        if (!is_nop && op_q != OpCmp) rf_d[dst_q] = res_q;
        if (!is_nop && (wf_q || op_q == OpCmp)) flags_d = nflags_q;
        rsp_valid_d = 1'b1;
        rsp_data_d  = res_q;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any in-flight operation.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= StIdle;
      op_q        <= '0;
      dst_q       <= '0;
      wf_q        <= 1'b0;
      imm_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      nflags_q    <= '0;
      flags_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
`ifdef PARAM_ALU_DATAPATH_MUL_EN
      mul_q       <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      dst_q       <= dst_d;
      wf_q        <= wf_d;
      imm_q       <= imm_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      nflags_q    <= nflags_d;
      flags_q     <= flags_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rf_q        <= rf_d;
`ifdef PARAM_ALU_DATAPATH_MUL_EN
      mul_q       <= mul_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_param_alu_datapath.sv
// Bench for param_alu_datapath: an arithmetic reference model updated at every
// accept feeds a queue of expected responses that a negedge monitor checks.
module tb_param_alu_datapath;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned NREG  = 8;
  localparam int unsigned RAW   = 3;

  logic             Clock = 1'b0;
  logic             Reset = 1'b0;
  logic             Req_Valid, Req_Ready, Req_WF;
  logic [3:0]       Req_Op;
  logic [RAW-1:0]   Req_Dst, Req_SrcA, Req_SrcB, Dbg_Sel;
  logic [WIDTH-1:0] Req_Imm, Rsp_Data, Dbg_Data;
  logic             Rsp_Valid;
  logic [3:0]       FlagsOut;

  param_alu_datapath #(.WIDTH(WIDTH), .NREG(NREG)) dut (
    .Clock(Clock), .Reset(Reset), .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
    .Req_Op(Req_Op), .Req_Dst(Req_Dst), .Req_SrcA(Req_SrcA), .Req_SrcB(Req_SrcB),
    .Req_Imm(Req_Imm), .Req_WF(Req_WF), .Rsp_Valid(Rsp_Valid), .Rsp_Data(Rsp_Data),
    .FlagsOut(FlagsOut), .Dbg_Sel(Dbg_Sel), .Dbg_Data(Dbg_Data)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  flags;
    int          due;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          acc_q[$];
  logic [15:0] rf_m [8];
  logic [3:0]  flags_m;
  int          total = 0, bad = 0, cyc = 0, rsp_cnt = 0, last_lat = 0;
  logic [15:0] last_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural state.
  function automatic void alu_model(input logic [3:0] op, input logic [15:0] a, b, imm,
                                    input logic [3:0] fin, input bit wf,
                                    output logic [15:0] r, output logic [3:0] fout,
                                    output bit wr);
    longint unsigned u;
    int  sa, sb, s;
    bit  cf, of, cu, ou, nop;
    cf = fin[2]; of = fin[0]; cu = 0; ou = 0; nop = 0; r = '0;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      4'h0: r = a;
      4'h1: r = imm;
      4'h2, 4'h3: begin
        u  = longint'(a) + longint'(b) + ((op == 4'h3 && fin[2]) ? 1 : 0);
        r  = 16'(u);
        cf = (u > 65535);
        s  = sa + sb + ((op == 4'h3 && fin[2]) ? 1 : 0);
        of = (s > 32767) || (s < -32768);
        cu = 1; ou = 1;
      end
      4'h4, 4'hE: begin
        r  = a - b;
        cf = (a >= b);
        s  = sa - sb;
        of = (s > 32767) || (s < -32768);
        cu = 1; ou = 1;
      end
      4'h5: r = a & b;
      4'h6: r = a | b;
      4'h7: r = a ^ b;
      4'h8: r = ~a;
      4'h9: begin r = a << 1; cf = a[15]; cu = 1; end
      4'hA: begin r = a >> 1; cf = a[0]; cu = 1; end
      4'hB: begin r = $signed(a) >>> 1; cf = a[0]; cu = 1; end
      4'hC: begin r = (a << 1) | 16'(fin[2]); cf = a[15]; cu = 1; end
      4'hD: begin r = (a >> 1) | (fin[2] ? 16'h8000 : 16'h0000); cf = a[0]; cu = 1; end
      default: begin
`ifdef PARAM_ALU_DATAPATH_MUL_EN
        u  = longint'(a) * longint'(b);
        r  = 16'(u);
        cf = ((u >> 16) != 0);
        cu = 1;
`else
        nop = 1;
        r   = '0;
`endif
      end
    endcase
    fout = fin;
    if (!nop && (wf || op == 4'hE)) begin
      fout[3] = (r == 16'h0000);
      fout[1] = r[15];
      if (cu) fout[2] = cf;
      if (ou) fout[0] = of;
    end
    wr = !(nop || op == 4'hE);
  endfunction

  // Monitor: retire expected responses, check handshake, model every accept.
  always @(negedge Clock) begin
    exp_t        e;
    logic [15:0] r;
    logic [3:0]  nf;
    bit          wr;
    cyc++;
    if (!Reset) begin
      q.delete();
      for (int i = 0; i < 8; i++) rf_m[i] = '0;
      flags_m = '0;
    end else begin
      if (Rsp_Valid) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL rsp_unexpected: got Rsp_Valid=1 data %0h want no response (cycle %0d)",
                   Rsp_Data, cyc);
        end else begin
          e = q.pop_front();
          chk("rsp_cycle", cyc, e.due);
          chk("rsp_data", Rsp_Data, e.data);
          chk("rsp_flags", FlagsOut, e.flags);
          last_lat  = cyc - e.acc - 1;
          last_data = Rsp_Data;
          rsp_cnt++;
        end
      end else if (q.size() != 0 && cyc >= q[0].due) begin
        total++; bad++;
        $display("FAIL rsp_missing: got no response want data %0h at cycle %0d",
                 q[0].data, q[0].due);
        void'(q.pop_front());
      end
      chk("req_ready", Req_Ready, q.size() == 0);
      if (Req_Valid && Req_Ready) begin
        alu_model(Req_Op, rf_m[Req_SrcA], rf_m[Req_SrcB], Req_Imm, flags_m, Req_WF, r, nf, wr);
        if (wr) rf_m[Req_Dst] = r;
        flags_m = nf;
        e.data  = r;
        e.flags = nf;
        e.acc   = cyc;
        e.due   = cyc + 3;
`ifdef PARAM_ALU_DATAPATH_MUL_EN
        if (Req_Op == 4'hF) e.due = cyc + 3 + int'(WIDTH);
`endif
        q.push_back(e);
        acc_q.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [3:0] op, input int dst, sa, sb, input logic [15:0] imm,
                      input bit wf, input bit hold);
    bit rdy, ok;
    ok = 0;
    @(posedge Clock); #2;
    Req_Op = op; Req_Dst = 3'(dst); Req_SrcA = 3'(sa); Req_SrcB = 3'(sb);
    Req_Imm = imm; Req_WF = wf; Req_Valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      rdy = Req_Ready;
      @(posedge Clock); #2;
      if (rdy) begin ok = 1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout: got Req_Ready=0 want 1 for op %0h", op);
    end
    if (!hold) Req_Valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge Clock); #1;
      n++;
    end
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL idle_timeout: got %0d pending want 0", q.size());
      q.delete();
    end
    @(negedge Clock); #1;
  endtask

  task automatic rd(input int i, output logic [15:0] v);
    Dbg_Sel = 3'(i);
    #1;
    v = Dbg_Data;
  endtask

  task automatic check_rf();
    logic [15:0] v;
    for (int i = 0; i < 8; i++) begin
      rd(i, v);
      chk($sformatf("rf%0d", i), v, rf_m[i]);
    end
  endtask

  task automatic check_rf_zero();
    logic [15:0] v;
    for (int i = 0; i < 8; i++) begin
      rd(i, v);
      chk($sformatf("rf%0d_zero", i), v, 16'h0000);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    int a0, r0;
    Req_Valid = 0; Req_Op = '0; Req_Dst = '0; Req_SrcA = '0; Req_SrcB = '0;
    Req_Imm = '0; Req_WF = 0; Dbg_Sel = '0;
    repeat (3) @(negedge Clock);
    @(posedge Clock); #2 Reset = 1'b1;
    @(negedge Clock); #1;
    chk("rst_ready", Req_Ready, 1);
    chk("rst_rsp_valid", Rsp_Valid, 0);
    chk("rst_rsp_data", Rsp_Data, 0);
    chk("rst_flags", FlagsOut, 4'b0000);
    check_rf_zero();

    // Reset in the middle of EXEC of an ADD
    send(4'h1, 1, 0, 0, 16'h1234, 0, 0);
    send(4'h1, 2, 0, 0, 16'h5678, 0, 0);
    wait_idle();
    check_rf();
    send(4'h2, 0, 1, 2, 16'h0000, 1, 0);
    #1 Reset = 1'b0;
    repeat (2) @(negedge Clock);
    @(posedge Clock); #2 Reset = 1'b1;
    @(negedge Clock); #1;
    chk("abort_ready", Req_Ready, 1);
    chk("abort_flags", FlagsOut, 4'b0000);
    check_rf_zero();
    repeat (6) @(negedge Clock);
    #1;

    // ADD with signed overflow
    send(4'h1, 1, 0, 0, 16'h7FFF, 0, 0);
    send(4'h1, 2, 0, 0, 16'h0001, 0, 0);
    send(4'h2, 3, 1, 2, 16'h0000, 1, 0);
    wait_idle();
    chk("add_data", last_data, 16'h8000);
    chk("add_latency", last_lat, 2);
    chk("add_flags", FlagsOut, 4'b0011);
    rd(3, v); chk("add_r3", v, 16'h8000);

    // SUB to zero, then CMP without writing
    send(4'h1, 4, 0, 0, 16'h0005, 0, 0);
    send(4'h4, 5, 4, 4, 16'h0000, 1, 0);
    wait_idle();
    chk("sub_data", last_data, 16'h0000);
    chk("sub_flags", FlagsOut, 4'b1100);
    send(4'hE, 5, 4, 5, 16'h0000, 0, 0);
    wait_idle();
    chk("cmp_data", last_data, 16'h0005);
    chk("cmp_flags", FlagsOut, 4'b0100);
    rd(5, v); chk("cmp_r5", v, 16'h0000);

    // Clear C, then rotate through carry both ways
    send(4'h2, 7, 0, 0, 16'h0000, 1, 0);
    send(4'h1, 6, 0, 0, 16'h8001, 0, 0);
    send(4'hC, 6, 6, 0, 16'h0000, 1, 0);
    wait_idle();
    rd(6, v); chk("csl_r6", v, 16'h0002);
    chk("csl_flags", FlagsOut, 4'b0100);
    send(4'hD, 6, 6, 0, 16'h0000, 1, 0);
    wait_idle();
    rd(6, v); chk("csr_r6", v, 16'h8001);
    chk("csr_flags", FlagsOut, 4'b0010);

    // ADD with WF=0 keeps flags
    send(4'h2, 1, 1, 2, 16'h0000, 0, 0);
    wait_idle();
    chk("add_nowf_flags", FlagsOut, 4'b0010);
    rd(1, v); chk("add_nowf_r1", v, 16'h8000);

    // Four requests with Req_Valid held high
    a0 = acc_q.size();
    r0 = rsp_cnt;
    send(4'h7, 2, 1, 6, 16'h0000, 0, 1);
    send(4'h8, 7, 4, 0, 16'h0000, 0, 1);
    send(4'h6, 0, 4, 6, 16'h0000, 0, 1);
    send(4'hA, 0, 6, 0, 16'h0000, 1, 0);
    wait_idle();
    chk("b2b_accepts", acc_q.size() - a0, 4);
    chk("b2b_responses", rsp_cnt - r0, 4);
    for (int i = 1; i < 4; i++)
      if (acc_q.size() > a0 + i) chk("b2b_gap", acc_q[a0 + i] - acc_q[a0 + i - 1], 3);
    chk("b2b_flags", FlagsOut, 4'b0100);
    rd(2, v); chk("b2b_r2", v, 16'h0001);
    rd(7, v); chk("b2b_r7", v, 16'hFFFA);

    // ADC, SUB overflow, ASR, LSL
    send(4'h3, 3, 4, 5, 16'h0000, 1, 0);
    wait_idle();
    rd(3, v); chk("adc_r3", v, 16'h0006);
    chk("adc_flags", FlagsOut, 4'b0000);
    send(4'h1, 1, 0, 0, 16'h8000, 0, 0);
    send(4'h4, 2, 1, 4, 16'h0000, 1, 0);
    wait_idle();
    chk("subov_data", last_data, 16'h7FFB);
    chk("subov_flags", FlagsOut, 4'b0101);
    send(4'hB, 0, 1, 0, 16'h0000, 1, 0);
    wait_idle();
    chk("asr_data", last_data, 16'hC000);
    chk("asr_flags", FlagsOut, 4'b0011);
    send(4'h9, 0, 1, 0, 16'h0000, 1, 0);
    wait_idle();
    chk("lsl_data", last_data, 16'h0000);
    chk("lsl_flags", FlagsOut, 4'b1101);

    // Opcode F: MUL when built in, NOP otherwise
    send(4'h1, 1, 0, 0, 16'h0012, 0, 0);
    send(4'h1, 2, 0, 0, 16'h0034, 0, 0);
    send(4'hF, 3, 1, 2, 16'h0000, 1, 0);
    wait_idle();
    rd(3, v);
`ifdef PARAM_ALU_DATAPATH_MUL_EN
    chk("mul_data", last_data, 16'h03A8);
    chk("mul_latency", last_lat, WIDTH + 2);
    chk("mul_r3", v, 16'h03A8);
    chk("mul_flags", FlagsOut, 4'b0001);
`else
    chk("nop_data", last_data, 16'h0000);
    chk("nop_latency", last_lat, 2);
    chk("nop_r3", v, 16'h0006);
    chk("nop_flags", FlagsOut, 4'b1101);
`endif
    check_rf();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_alu_datapath.md
Name: param_alu_datapath

Overview:
- Parametrised successor to the fixed 16-bit register-file/ALU datapath of the basic computer.
- Holds an NREG x WIDTH general register file, a WIDTH-bit ALU and a 4-bit flag register behind a valid/ready request interface.
- A small FSM sequences each operation: operand read, execute, then writeback of the register and flags.
- Sits between the future instruction decoder and the register/ALU resources, replacing the hand-driven select lines.

Parameters:
- WIDTH, 16: datapath and register width in bits (≥4).
- NREG, 8: number of general registers (power of 2, ≥2).
- RAW, $clog2(NREG): register index width (derived, do not override).

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- Req_Valid  in  1  request present.
- Req_Ready  out  1  block can accept a request.
- Req_Op  in  4  opcode.
- Req_Dst  in  RAW  destination register index.
- Req_SrcA  in  RAW  operand A register index.
- Req_SrcB  in  RAW  operand B register index.
- Req_Imm  in  WIDTH  immediate for LDI.
- Req_WF  in  1  write flags for this operation.
- Rsp_Valid  out  1  one-cycle pulse: operation retired.
- Rsp_Data  out  WIDTH  result of the retired operation.
- FlagsOut  out  4  {Z,C,N,O}.
- Dbg_Sel  in  RAW  debug read index.
- Dbg_Data  out  WIDTH  combinational read of RF[Dbg_Sel].

Behaviour:
- Reset (async, Reset=0) clears all of the following immediately:
  - all registers, FlagsOut, Rsp_Data and Rsp_Valid to 0;
  - FSM to IDLE, so Req_Ready=1 once Reset=1.
- FSM states: IDLE -> EXEC -> WB -> IDLE; optional MUL state (see feature).
- IDLE: Req_Ready=1. On Req_Valid&&Req_Ready at edge k:
  - latch op, dst, WF, imm, RF[SrcA] and RF[SrcB];
  - go to EXEC.
- EXEC: compute the result and next flags into pipeline registers at edge k+1; go to WB.
- WB, at edge k+2:
  - write RF[dst] (except CMP/NOP) and update flags if enabled;
  - load Rsp_Data and pulse Rsp_Valid=1 for exactly one cycle;
  - return to IDLE.
- Latency: accept to Rsp_Valid = 2 edges. Earliest next accept is edge k+3 (Req_Ready=0 in EXEC and WB).
- Operands are captured at accept, so Dst==SrcA/SrcB is legal and uses the old values. A request is never lost or duplicated.
- Opcodes (A, B = latched operands):
  - 0 MOV A; 1 LDI Imm;
  - 2 ADD A+B; 3 ADC A+B+C; 4 SUB A-B;
  - 5 AND; 6 OR; 7 XOR; 8 NOT A;
  - 9 LSL A; A LSR A; B ASR A;
  - C CSL (rotate left through C); D CSR (rotate right through C);
  - E CMP (A-B, no RF write); F MUL (optional) else NOP.
- Arithmetic and flag rules:
  - Arithmetic is modulo 2^WIDTH.
  - SUB/CMP: C=1 when A≥B unsigned (no borrow).
  - O is signed overflow for ADD/ADC/SUB/CMP.
- Flag update rules:
  - Flags update only when latched WF=1; CMP always updates flags.
  - Z and N update for all non-NOP ops.
  - C updates for arithmetic (carry-out) and shifts/rotates (bit shifted out); C is unchanged for MOV/LDI/logic.
  - O updates only for arithmetic.
  - ADC uses the flag C as it stood at accept.
- NOP (F without feature): no RF or flag write. Rsp_Valid still pulses, with Rsp_Data=0.
- Reset mid-operation aborts the in-flight op: no write occurs and no Rsp_Valid is issued.
- Dbg_Data reflects a WB write from the cycle after the WB edge.

Optional Feature:
- Macro: PARAM_ALU_DATAPATH_MUL_EN.
- With the macro defined, opcode F is MUL (low WIDTH bits of A*B):
  - EXEC enters MUL, an iterative shift-add taking exactly WIDTH cycles, then WB;
  - Req_Ready stays 0 throughout;
  - flags: Z, N from the low result; C=1 if the high half is nonzero; O unchanged.
- Without the macro, F is NOP, the MUL state and its logic are absent, and no multiplier hardware is inferred.

Test Plan:
- Reset asserted mid-EXEC of ADD -> Req_Ready=1 after release, Rsp_Valid never pulses, RF all 0, FlagsOut=0000.
- LDI R1=0x7FFF, LDI R2=0x0001, ADD R3=R1+R2 with WF=1 -> Rsp_Data=0x8000 two edges after accept; flags Z=0, C=0, N=1, O=1; Req_Ready low for 2 cycles.
- LDI R4=0x0005, SUB R5=R4-R4 with WF=1, then CMP R4,R5 -> first gives 0x0000 with Z=1, C=1; CMP leaves R5 unchanged with Z=0, C=1, N=0.
- LDI R6=0x8001, CSL R6 (C=0 at start) with WF=1 -> R6=0x0002, C=1; then CSR R6 -> R6=0x8001, C=0.
- Back-to-back Req_Valid held high for 4 requests -> accepts exactly every 3rd edge, 4 Rsp_Valid pulses, no drop or duplicate. ADD with WF=0 leaves FlagsOut unchanged.
- With the macro: R1=0x0012, R2=0x0034, MUL R3 -> R3=0x03A8, Rsp_Valid exactly WIDTH+2 edges after accept, C=0. Without the macro, F gives a Rsp_Valid pulse with Rsp_Data=0 and no RF change.
